// File: rtl/div_pkg.sv
// Shared types and constants for the sequential non-restoring divider.
// The signed/unsigned build choice (DIV_SIGNED_EN) lives in the top module.
package div_pkg;

    localparam int DIV_N_W   = 16;
    localparam int DIV_D_W   = 8;
    localparam int DIV_CNT_W = 5;

    // Quotient patterns reported for -32768/-1 and for a zero divisor
    localparam logic [15:0] DIV_Q_OVF = 16'h8000;
    localparam logic [15:0] DIV_Q_DBZ = 16'hFFFF;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ITER = 2'd1,
        FIX  = 2'd2,
        ZERO = 2'd3
    } div_state_e;

endpackage

// File: rtl/div_step.sv
// One radix-2 non-restoring step: shift the partial remainder left by one,
// bring in the next dividend bit, then add or subtract the divisor magnitude.
module div_step #(
    parameter int P_W = 10,
    parameter int B_W = 9
) (
    input  logic [P_W-1:0] p_i,
    input  logic           bit_i,
    input  logic [B_W-1:0] b_i,
    output logic [P_W-1:0] p_o,
    output logic           q_o
);

    logic [P_W-1:0] shifted;
    logic [P_W-1:0] b_ext;

    // The invariant -|b| <= P < |b| guarantees 2P never loses the sign bit
    assign shifted = {p_i[P_W-2:0], bit_i};
    assign b_ext   = P_W'(b_i);
    assign p_o     = p_i[P_W-1] ? (shifted + b_ext) : (shifted - b_ext);
    assign q_o     = ~p_o[P_W-1];

endmodule

// File: rtl/seq_nonrestoring_divider.sv
// Sequential radix-2 non-restoring divider, one quotient bit per clock.
// Define DIV_SIGNED_EN for two's-complement operands; otherwise operands are unsigned.
module seq_nonrestoring_divider
    import div_pkg::*;
#(
    parameter int N_W   = DIV_N_W,
    parameter int D_W   = DIV_D_W,
    parameter int CNT_W = DIV_CNT_W
) (
    input  logic           CLK,
    input  logic           RST,
    input  logic           en,
    input  logic [N_W-1:0] in_a,
    input  logic [D_W-1:0] in_b,
    output logic [N_W-1:0] Quotient,
    output logic [D_W-1:0] Remainder,
    output logic           busy,
    output logic           done,
    output logic           div_by_zero,
    output logic           overflow
);

    localparam int P_W = D_W + 2;

    div_state_e     state_q, state_d;
    // Dividend bits leave at the MSB while quotient bits enter at the LSB
    logic [N_W-1:0] aq_q, aq_d;
    logic [D_W:0]   b_mag_q, b_mag_d;
    logic [P_W-1:0] p_q, p_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [N_W-1:0] quot_q, quot_d;
    logic [D_W-1:0] rem_q, rem_d;
    logic           busy_q, busy_d;
    logic           done_q, done_d;
    logic           dbz_q, dbz_d;

    logic [N_W-1:0] a_mag;
    logic [D_W:0]   b_mag;
    logic [P_W-1:0] step_p;
    logic           step_q;
    logic [P_W-1:0] p_fix;
    logic [D_W-1:0] r_mag;

`ifdef DIV_SIGNED_EN
    logic           sign_a_q, sign_a_d;
    logic           sign_b_q, sign_b_d;
    logic           ovf_q, ovf_d;
    logic [D_W:0]   b_sext;
    logic           neg_q;

    assign b_sext = {in_b[D_W-1], in_b};
    assign a_mag  = in_a[N_W-1] ? -in_a : in_a;
    assign b_mag  = in_b[D_W-1] ? -b_sext : b_sext;
    assign neg_q  = sign_a_q ^ sign_b_q;
`else
    assign a_mag  = in_a;
    assign b_mag  = {1'b0, in_b};
`endif

    div_step #(
        .P_W (P_W),
        .B_W (D_W + 1)
    ) u_step (
        .p_i   (p_q),
        .bit_i (aq_q[N_W-1]),
        .b_i   (b_mag_q),
        .p_o   (step_p),
        .q_o   (step_q)
    );

    // Final correction brings a negative partial remainder back into [0, |b|)
    assign p_fix = p_q[P_W-1] ? (p_q + P_W'(b_mag_q)) : p_q;
    assign r_mag = D_W'(p_fix);

    always_comb begin
        state_d = state_q;
        aq_d    = aq_q;
        b_mag_d = b_mag_q;
        p_d     = p_q;
        cnt_d   = cnt_q;
        quot_d  = quot_q;
        rem_d   = rem_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        dbz_d   = dbz_q;
`ifdef DIV_SIGNED_EN
        sign_a_d = sign_a_q;
        sign_b_d = sign_b_q;
        ovf_d    = ovf_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (en) begin
                    aq_d    = a_mag;
                    b_mag_d = b_mag;
                    p_d     = '0;
                    cnt_d   = '0;
                    dbz_d   = 1'b0;
                    busy_d  = 1'b1;
`ifdef DIV_SIGNED_EN
                    sign_a_d = in_a[N_W-1];
                    sign_b_d = in_b[D_W-1];
                    ovf_d    = 1'b0;
`endif
                    state_d = (in_b == '0) ? ZERO : ITER;
                end
            end
            ITER: begin
                aq_d  = {aq_q[N_W-2:0], step_q};
                p_d   = step_p;
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(N_W - 1)) begin
                    state_d = FIX;
                end
            end
            FIX: begin
`ifdef DIV_SIGNED_EN
                quot_d = neg_q ? -aq_q : aq_q;
                rem_d  = sign_a_q ? -r_mag : r_mag;
                // Only -2^(N_W-1) / -1 yields a positive magnitude of 2^(N_W-1)
                ovf_d  = ~neg_q && (aq_q == N_W'(DIV_Q_OVF));
`else
                quot_d = aq_q;
                rem_d  = r_mag;
`endif
                busy_d  = 1'b0;
                done_d  = 1'b1;
                state_d = IDLE;
            end
            ZERO: begin
                quot_d  = N_W'(DIV_Q_DBZ);
                rem_d   = '0;
                dbz_d   = 1'b1;
                busy_d  = 1'b0;
                done_d  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= IDLE;
            aq_q    <= '0;
            b_mag_q <= '0;
            p_q     <= '0;
            cnt_q   <= '0;
            quot_q  <= '0;
            rem_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            dbz_q   <= 1'b0;
`ifdef DIV_SIGNED_EN
            sign_a_q <= 1'b0;
            sign_b_q <= 1'b0;
            ovf_q    <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            aq_q    <= aq_d;
            b_mag_q <= b_mag_d;
            p_q     <= p_d;
            cnt_q   <= cnt_d;
            quot_q  <= quot_d;
            rem_q   <= rem_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            dbz_q   <= dbz_d;
`ifdef DIV_SIGNED_EN
            sign_a_q <= sign_a_d;
            sign_b_q <= sign_b_d;
            ovf_q    <= ovf_d;
`endif
        end
    end

    assign Quotient    = quot_q;
    assign Remainder   = rem_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign div_by_zero = dbz_q;
`ifdef DIV_SIGNED_EN
    assign overflow    = ovf_q;
`else
    assign overflow    = 1'b0;
`endif

endmodule

// File: tb/tb_seq_nonrestoring_divider.sv
// Self-checking bench for seq_nonrestoring_divider; follows DIV_SIGNED_EN to pick
// the signed or unsigned reference behaviour.
module tb_seq_nonrestoring_divider;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        en = 1'b0;
    logic [15:0] in_a = '0;
    logic [7:0]  in_b = '0;
    logic [15:0] Quotient;
    logic [7:0]  Remainder;
    logic        busy, done, div_by_zero, overflow;

    int errors = 0;
    int checks = 0;

    typedef struct packed {
        logic [15:0] a;
        logic [7:0]  b;
        logic [15:0] q;
        logic [7:0]  r;
        logic        dz;
        logic        ov;
    } vec_t;

    seq_nonrestoring_divider dut (
        .CLK         (CLK),
        .RST         (RST),
        .en          (en),
        .in_a        (in_a),
        .in_b        (in_b),
        .Quotient    (Quotient),
        .Remainder   (Remainder),
        .busy        (busy),
        .done        (done),
        .div_by_zero (div_by_zero),
        .overflow    (overflow)
    );

    always #5 CLK = ~CLK;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Reference: plain integer division, truncation toward zero
    function automatic void model(input logic [15:0] a, input logic [7:0] b,
                                  output logic [15:0] q, output logic [7:0] r,
                                  output logic dz, output logic ov);
        int x, y;
        dz = 1'b0;
        ov = 1'b0;
`ifdef DIV_SIGNED_EN
        x = $signed(a);
        y = $signed(b);
`else
        x = int'(a);
        y = int'(b);
`endif
        if (y == 0) begin
            q = 16'hFFFF; r = 8'h00; dz = 1'b1;
        end else if (x == -32768 && y == -1) begin
            q = 16'h8000; r = 8'h00; ov = 1'b1;
        end else begin
            q = 16'(x / y);
            r = 8'(x % y);
        end
    endfunction

    // Drives one en pulse; returns at the falling edge after the capture edge
    task automatic start_op(input logic [15:0] a, input logic [7:0] b);
        @(negedge CLK);
        in_a = a; in_b = b; en = 1'b1;
        @(negedge CLK);
        en = 1'b0;
    endtask

    // Counts rising edges until done is seen; -1 if it never comes
    task automatic wait_done(output int lat);
        lat = -1;
        for (int i = 1; i <= 40; i++) begin
            @(posedge CLK);
            @(negedge CLK);
            if (done) begin
                lat = i;
                break;
            end
        end
    endtask

    task automatic test_reset();
        @(negedge CLK);
        checks++;
        if ({Quotient, Remainder, busy, done, div_by_zero, overflow} !== 28'h0) begin
            errors++;
            $display("FAIL reset_held: got q=%h r=%h busy=%b done=%b dz=%b ov=%b, expected all 0",
                     Quotient, Remainder, busy, done, div_by_zero, overflow);
        end
        RST = 1'b0;
        @(negedge CLK);
        checks++;
        if ({Quotient, Remainder, busy, done} !== 26'h0) begin
            errors++;
            $display("FAIL reset_release: got q=%h r=%h busy=%b done=%b, expected all 0",
                     Quotient, Remainder, busy, done);
        end
        $display("reset: released");
    endtask

    task automatic test_directed();
        vec_t v [6];
        int lat, exp_lat;
`ifdef DIV_SIGNED_EN
        v[0] = '{a:16'd100,   b:8'd7,   q:16'd14,    r:8'd2,   dz:1'b0, ov:1'b0};
        v[1] = '{a:16'hFF9C,  b:8'd7,   q:16'hFFF2,  r:8'hFE,  dz:1'b0, ov:1'b0};
        v[2] = '{a:16'd32767, b:8'h80,  q:16'hFF01,  r:8'h7F,  dz:1'b0, ov:1'b0};
        v[3] = '{a:16'h8000,  b:8'hFF,  q:16'h8000,  r:8'h00,  dz:1'b0, ov:1'b1};
        v[4] = '{a:16'd6,     b:8'd3,   q:16'd2,     r:8'd0,   dz:1'b0, ov:1'b0};
        v[5] = '{a:16'd1234,  b:8'd0,   q:16'hFFFF,  r:8'h00,  dz:1'b1, ov:1'b0};
`else
        v[0] = '{a:16'd100,   b:8'd7,   q:16'd14,    r:8'd2,   dz:1'b0, ov:1'b0};
        v[1] = '{a:16'd65535, b:8'd255, q:16'd257,   r:8'd0,   dz:1'b0, ov:1'b0};
        v[2] = '{a:16'd32767, b:8'h80,  q:16'd255,   r:8'd127, dz:1'b0, ov:1'b0};
        v[3] = '{a:16'h8000,  b:8'hFF,  q:16'd128,   r:8'd128, dz:1'b0, ov:1'b0};
        v[4] = '{a:16'd6,     b:8'd3,   q:16'd2,     r:8'd0,   dz:1'b0, ov:1'b0};
        v[5] = '{a:16'd1234,  b:8'd0,   q:16'hFFFF,  r:8'h00,  dz:1'b1, ov:1'b0};
`endif
        for (int i = 0; i < 6; i++) begin
            exp_lat = v[i].dz ? 1 : 17;
            start_op(v[i].a, v[i].b);
            checks++;
            if (busy !== 1'b1) begin
                errors++;
                $display("FAIL dir%0d_busy_capture: got %b expected 1", i, busy);
            end
            wait_done(lat);
            checks++;
            if (lat != exp_lat) begin
                errors++;
                $display("FAIL dir%0d_latency: got %0d expected %0d", i, lat, exp_lat);
            end
            checks++;
            if (Quotient !== v[i].q) begin
                errors++;
                $display("FAIL dir%0d_quotient: got %h expected %h", i, Quotient, v[i].q);
            end
            checks++;
            if (Remainder !== v[i].r) begin
                errors++;
                $display("FAIL dir%0d_remainder: got %h expected %h", i, Remainder, v[i].r);
            end
            checks++;
            if ({div_by_zero, overflow, busy} !== {v[i].dz, v[i].ov, 1'b0}) begin
                errors++;
                $display("FAIL dir%0d_flags: got dz=%b ov=%b busy=%b expected dz=%b ov=%b busy=0",
                         i, div_by_zero, overflow, busy, v[i].dz, v[i].ov);
            end
            @(negedge CLK);
            checks++;
            if (done !== 1'b0) begin
                errors++;
                $display("FAIL dir%0d_done_pulse: got %b expected 0", i, done);
            end
            $display("directed %0d: a=%h b=%h -> q=%h r=%h dz=%b ov=%b lat=%0d",
                     i, v[i].a, v[i].b, Quotient, Remainder, div_by_zero, overflow, lat);
        end
    endtask

    task automatic test_random();
        logic [15:0] a, eq;
        logic [7:0]  b, er;
        logic        edz, eov;
        int          lat, sel;
        for (int i = 0; i < 40; i++) begin
            a = 16'($urandom);
            b = 8'($urandom);
            sel = $urandom_range(0, 9);
            if (sel == 0) b = 8'h00;
            if (sel == 1) begin a = 16'h8000; b = 8'hFF; end
            if (sel == 2) b = 8'h80;
            if (sel == 3) b = 8'h01;
            model(a, b, eq, er, edz, eov);
            start_op(a, b);
            wait_done(lat);
            checks++;
            if (lat != (edz ? 1 : 17)) begin
                errors++;
                $display("FAIL rnd%0d_latency: got %0d expected %0d", i, lat, edz ? 1 : 17);
            end
            checks++;
            if ({Quotient, Remainder} !== {eq, er}) begin
                errors++;
                $display("FAIL rnd%0d_result: a=%h b=%h got q=%h r=%h expected q=%h r=%h",
                         i, a, b, Quotient, Remainder, eq, er);
            end
            checks++;
            if ({div_by_zero, overflow} !== {edz, eov}) begin
                errors++;
                $display("FAIL rnd%0d_flags: got dz=%b ov=%b expected dz=%b ov=%b",
                         i, div_by_zero, overflow, edz, eov);
            end
            $display("random %0d: a=%h b=%h -> q=%h r=%h dz=%b ov=%b",
                     i, a, b, Quotient, Remainder, div_by_zero, overflow);
        end
    endtask

    task automatic test_busy_ignore();
        int lat;
        start_op(16'd500, 8'd9);
        repeat (4) @(negedge CLK);
        in_a = 16'd1000; in_b = 8'd3; en = 1'b1;
        @(negedge CLK);
        en = 1'b0;
        wait_done(lat);
        checks++;
        if (lat + 5 != 17) begin
            errors++;
            $display("FAIL busy_ignore_latency: got %0d expected 17", lat + 5);
        end
        checks++;
        if ({Quotient, Remainder} !== {16'd55, 8'd5}) begin
            errors++;
            $display("FAIL busy_ignore_result: got q=%0d r=%0d expected q=55 r=5", Quotient, Remainder);
        end
        $display("busy_ignore: 500/9 with en at iter 5 -> q=%0d r=%0d", Quotient, Remainder);
    endtask

    task automatic test_reset_abort();
        int seen = 0;
        start_op(16'd500, 8'd9);
        repeat (7) @(negedge CLK);
        RST = 1'b1;
        #1;
        checks++;
        if ({Quotient, Remainder, busy, done, div_by_zero, overflow} !== 28'h0) begin
            errors++;
            $display("FAIL reset_abort_outputs: got q=%h r=%h busy=%b done=%b dz=%b ov=%b, expected all 0",
                     Quotient, Remainder, busy, done, div_by_zero, overflow);
        end
        @(negedge CLK);
        RST = 1'b0;
        for (int i = 0; i < 25; i++) begin
            @(negedge CLK);
            if (done) seen++;
        end
        checks++;
        if (seen != 0) begin
            errors++;
            $display("FAIL reset_abort_done: got %0d done pulses expected 0", seen);
        end
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_abort_busy: got %b expected 0", busy);
        end
        $display("reset_abort: reset at iter 8, done pulses=%0d", seen);
    endtask

    task automatic test_back_to_back();
        logic [15:0] a1, a2, q1, q2;
        logic [7:0]  b1, b2, r1, r2;
        logic        d1, d2, o1, o2;
        int          lat;
        a1 = 16'($urandom); b1 = 8'($urandom_range(1, 255));
        a2 = 16'($urandom); b2 = 8'($urandom_range(1, 255));
        model(a1, b1, q1, r1, d1, o1);
        model(a2, b2, q2, r2, d2, o2);
        @(negedge CLK);
        in_a = a1; in_b = b1; en = 1'b1;
        @(negedge CLK);
        in_a = a2; in_b = b2;
        wait_done(lat);
        checks++;
        if ({lat, Quotient, Remainder, busy} !== {32'(17), q1, r1, 1'b0}) begin
            errors++;
            $display("FAIL b2b_first: got lat=%0d q=%h r=%h busy=%b expected lat=17 q=%h r=%h busy=0",
                     lat, Quotient, Remainder, busy, q1, r1);
        end
        @(negedge CLK);
        en = 1'b0;
        checks++;
        if ({busy, done} !== 2'b10) begin
            errors++;
            $display("FAIL b2b_recapture: got busy=%b done=%b expected busy=1 done=0", busy, done);
        end
        wait_done(lat);
        checks++;
        if ({lat, Quotient, Remainder} !== {32'(17), q2, r2}) begin
            errors++;
            $display("FAIL b2b_second: got lat=%0d q=%h r=%h expected lat=17 q=%h r=%h",
                     lat, Quotient, Remainder, q2, r2);
        end
        $display("back_to_back: %h/%h then %h/%h -> q=%h r=%h", a1, b1, a2, b2, Quotient, Remainder);
    endtask

    initial begin
        test_reset();
        test_directed();
        test_random();
        test_busy_ignore();
        test_reset_abort();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
